// File: rtl/mf_controller.sv
// Sequencing and display-scan controller for the 4-bit multifunction calculator:
// button sync/debounce, press resolution, operand latch, one-hot mode, digit multiplexing.

module mf_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) {q, meta} <= 2'b00;
    else        {q, meta} <= {meta, d};
  end
endmodule

module mf_controller #(
  parameter int DEB_CYCLES  = 16,
  parameter int SCAN_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_add,
  input  logic       btn_cmp,
  input  logic       btn_max,
  input  logic       btn_min,
  input  logic       clr,
  input  logic [3:0] sw_a,
  input  logic [3:0] sw_b,
  input  logic [6:0] seg_h,
  input  logic [6:0] seg_l,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       m_add,
  output logic       m_cmp,
  output logic       m_max,
  output logic       m_min,
  output logic       start,
  output logic [6:0] seg_out,
  output logic [1:0] dig_sel
);
  localparam int NUM_BTN = 4;
  localparam int CW      = $clog2(DEB_CYCLES + 1);
  localparam int PW      = $clog2(SCAN_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_REL, S_ACT} state_t;

  typedef struct packed {
    state_t               st;
    logic [CW-1:0]        cnt;
    logic [NUM_BTN-1:0]   snap;
    logic [NUM_BTN-1:0]   mode;
    logic [3:0]           op_a;
    logic [3:0]           op_b;
    logic                 start;
  } ctrl_t;

  logic [NUM_BTN-1:0] btn_raw, btn_s;
  ctrl_t              r, r_nx;
  logic [PW-1:0]      pc;
  logic               ph;

  // Bit order {add,cmp,max,min}: the MSB carries the highest priority.
  assign btn_raw = {btn_add, btn_cmp, btn_max, btn_min};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_sync
    mf_sync u_sync (.clk(clk), .rst_n(rst_n), .d(btn_raw[g]), .q(btn_s[g]));
  end

  function automatic logic [NUM_BTN-1:0] prio1h(input logic [NUM_BTN-1:0] s);
    casez (s)
      4'b1???: return 4'b1000;
      4'b01??: return 4'b0100;
      4'b001?: return 4'b0010;
      default: return {3'b000, s[0]};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) r <= '0;
    else        r <= r_nx;
  end

  always_comb begin
    r_nx       = r;
    r_nx.start = 1'b0;
    case (r.st)
      S_IDLE, S_ACT: begin
        if (btn_s != '0) begin
          r_nx.st   = S_ARM;
          r_nx.snap = btn_s;
          r_nx.cnt  = CW'(1);
        end
      end
      S_ARM: begin
        if (btn_s == '0) begin
          // Aborted press: fall back without touching mode or operands.
          r_nx.st  = (r.mode != '0) ? S_ACT : S_IDLE;
          r_nx.cnt = '0;
        end else if (btn_s != r.snap) begin
          r_nx.snap = btn_s;
          r_nx.cnt  = CW'(1);
        end else if (r.cnt == CW'(DEB_CYCLES - 1)) begin
          r_nx.st    = S_REL;
          r_nx.cnt   = '0;
          r_nx.mode  = prio1h(r.snap);
          r_nx.op_a  = sw_a;
          r_nx.op_b  = sw_b;
          r_nx.start = 1'b1;
        end else begin
          r_nx.cnt = r.cnt + CW'(1);
        end
      end
      S_REL: begin
        if (btn_s != '0) begin
          r_nx.cnt = '0;
        end else if (r.cnt == CW'(DEB_CYCLES - 1)) begin
          r_nx.st  = S_ACT;
          r_nx.cnt = '0;
        end else begin
          r_nx.cnt = r.cnt + CW'(1);
        end
      end
      default: r_nx.st = S_IDLE;
    endcase
    if (clr) begin
      r_nx.st    = S_IDLE;
      r_nx.cnt   = '0;
      r_nx.mode  = '0;
      r_nx.op_a  = '0;
      r_nx.op_b  = '0;
      r_nx.start = 1'b0;
    end
  end

  // Free-running scan; never restarted by mode changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= '0;
      ph      <= 1'b0;
      seg_out <= 7'h00;
      dig_sel <= 2'b11;
    end else begin
      if (pc == PW'(SCAN_CYCLES - 1)) begin
        pc <= '0;
        ph <= ~ph;
      end else begin
        pc <= pc + PW'(1);
      end
      if (r.mode != '0) begin
        seg_out <= ph ? seg_l : seg_h;
        dig_sel <= ph ? 2'b10 : 2'b01;
      end else begin
        seg_out <= 7'h00;
        dig_sel <= 2'b11;
      end
    end
  end

  assign {m_add, m_cmp, m_max, m_min} = r.mode;
  assign op_a  = r.op_a;
  assign op_b  = r.op_b;
  assign start = r.start;
endmodule

// File: doc/mf_controller.md
# mf_controller

Sequencing and display-scheduling controller for the 4-bit multifunction calculator datapath (add, compare, max, min). It synchronises and debounces the four raw function buttons, resolves simultaneous presses, latches both operands at commit time, and holds a one-hot mode vector that drives the datapath's button inputs. It also time-multiplexes the datapath's two 7-segment digit codes onto one shared segment bus with two digit enables.

## Interface
- DEB_CYCLES, 16: consecutive stable cycles required to accept a press or a release; legal range ≥ 2.
- SCAN_CYCLES, 8: cycles each digit is shown per scan phase; legal range ≥ 1.

- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- btn_add, btn_cmp, btn_max, btn_min  in  1 each  raw asynchronous buttons, active-high.
- clr  in  1  synchronous mode clear, active-high.
- sw_a, sw_b  in  4 each  raw operand switches.
- seg_h, seg_l  in  7 each  high- and low-digit segment codes from the datapath.
- op_a, op_b  out  4 each  operands latched at commit; they drive the datapath din1 and din2.
- m_add, m_cmp, m_max, m_min  out  1 each  held one-hot mode; they drive the datapath button inputs.
- start  out  1  one-cycle pulse on every commit.
- seg_out  out  7  shared segment bus.
- dig_sel  out  2  digit enables, active-low; bit1 is the high digit, bit0 is the low digit.

## Operation
- Raw buttons pass through 2-flop synchronisers to form btn_s[3:0]. Bit order is {add,cmp,max,min}.
- sw_a and sw_b are sampled directly at commit. The switches must be static while a button is pressed.
- FSM states:
  - IDLE: mode is all zeros.
  - ARM: debouncing a press.
  - RELEASE: waiting for all buttons to be released.
  - ACTIVE: mode is held.
- IDLE or ACTIVE, btn_s nonzero → ARM. Capture snap = btn_s and set cnt = 1.
- ARM behaviour on each edge:
  - btn_s == snap and cnt == DEB_CYCLES-1 → commit.
  - btn_s == snap otherwise → cnt += 1.
  - btn_s nonzero but != snap → restart: snap = btn_s, cnt = 1.
  - btn_s == 0 → return to ACTIVE if mode is nonzero, else IDLE. Mode and operands are unchanged.
- Commit, in one edge:
  - Priority is add > cmp > max > min. The mode becomes the highest set bit of snap, exactly one-hot.
  - op_a ← sw_a, op_b ← sw_b, start = 1 for one cycle.
  - Next state is RELEASE.
- RELEASE: cnt counts consecutive cycles with btn_s == 0 and resets to 0 on any nonzero btn_s. Reaching DEB_CYCLES → ACTIVE. A press during RELEASE does not commit.
- ACTIVE: mode and operands are held indefinitely.
- clr, evaluated in every state, has priority over everything else:
  - next state IDLE;
  - mode, op_a, op_b and cnt are zeroed;
  - start is 0, even if a commit would have occurred on that edge.
- Display scan:
  - Free-running phase counter pc cycles 0..SCAN_CYCLES-1. ph toggles when pc wraps.
  - Mode nonzero: ph=0 gives dig_sel=2'b01 and seg_out=seg_h; ph=1 gives dig_sel=2'b10 and seg_out=seg_l.
  - Mode zero: dig_sel=2'b11 and seg_out=7'h00 (blank).
- Counter widths: $clog2(DEB_CYCLES+1) for cnt and $clog2(SCAN_CYCLES+1) for pc. Neither counter may overflow or wrap except where specified above.

## Timing
- Reset values:
  - state IDLE; synchronisers, cnt, pc and ph all 0;
  - mode 0, op_a and op_b 0, start 0;
  - seg_out 7'h00, dig_sel 2'b11.
- Reset is synchronous: it takes effect at the first edge with rst_n low. Reset mid-ARM or mid-ACTIVE discards all state, and no start pulse is issued.
- Press latency: raw button held stable → mode, op_a, op_b and start all update at edge DEB_CYCLES+2. Edge 1 is the first edge that samples the raw button high.
- Minimum press-to-press spacing: the commit edge, plus DEB_CYCLES release cycles, plus 2 synchroniser cycles.
- seg_out and dig_sel are registered: they reflect ph, mode and the seg_h/seg_l values sampled one edge earlier.
- Digit switch occurs exactly every SCAN_CYCLES cycles. The first displayed digit after a mode becomes nonzero is whichever ph is current; the scan is not restarted.
- start is never high for two consecutive cycles.

## Test plan
- DEB_CYCLES=4: hold btn_add with sw_a=9 and sw_b=8 → at edge 6, m_add=1, op_a=9, op_b=8 and start is high for exactly one cycle; the mode stays held after release.
- DEB_CYCLES=4: btn_cmp pulse of 3 cycles → no commit, and state returns to IDLE (or to ACTIVE with the prior mode unchanged).
- btn_max and btn_min raised on the same cycle and held → m_max=1, m_min=0. Then btn_add pressed alone after full release → switches to m_add, one-hot, with new operands latched.
- ACTIVE with m_min; press btn_add and assert clr on the would-be commit edge → mode 0, op_a=op_b=0, start stays 0, dig_sel=2'b11.
- SCAN_CYCLES=3 in ACTIVE, seg_h=7'h3F, seg_l=7'h06 → seg_out alternates 3F/06 with dig_sel 01/10, each held for 3 cycles. In IDLE, seg_out=00 and dig_sel=11.
- Reset asserted mid-ARM with btn_max held → all outputs at reset values. After rst_n rises with the button still held, a full DEB_CYCLES+2 debounce is required before the commit.
